// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matrix-vector MAC engine.
// Optional build macro MATVEC_MAC_SAT_EN: when defined, the WRITE narrowing
// saturates to the output range; otherwise it wraps (keeps the low bits).
package matvec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_DRAIN1 = 3'd2,
        ST_DRAIN2 = 3'd3,
        ST_DRAIN3 = 3'd4,
        ST_WRITE  = 3'd5
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int calc_bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    // Guard bits cover the NCOL-term sum of full-precision products.
    function automatic int calc_acc_w(input int bw, input int ncol);
        return 2 * bw + clog2(ncol);
    endfunction

    function automatic int calc_addr_w(input int ncol);
        return (clog2(ncol) < 1) ? 1 : clog2(ncol);
    endfunction

    // Narrows an already-shifted sum to bw bits; the caller keeps the low bw bits.
    function automatic logic signed [63:0] narrow_result(input logic signed [63:0] v,
                                                         input int bw);
`ifdef MATVEC_MAC_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - bw)) >>> (64 - bw);
`endif
    endfunction

endpackage

// File: rtl/matvec_mac_engine_mac_lane.sv
// One shared MAC lane: registered signed w*x, then accumulation into one of
// P per-group accumulators selected by the group index travelling with the data.
module mac_lane
    import matvec_pkg::*;
#(
    parameter int BITWIDTH = 18,
    parameter int ACC_W    = 38,
    parameter int P        = 4,
    parameter int GW       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic [GW-1:0]         grp_i,
    input  logic [BITWIDTH-1:0]   w_i,
    input  logic [BITWIDTH-1:0]   x_i,
    output logic [P*ACC_W-1:0]    acc_o
);

    localparam int PW = 2 * BITWIDTH;

    logic signed [PW-1:0]    w_ext;
    logic signed [PW-1:0]    x_ext;
    logic signed [PW-1:0]    prod_q;
    logic                    pv_q;
    logic [GW-1:0]           pg_q;
    logic signed [ACC_W-1:0] acc_q [P];

    assign w_ext = {{BITWIDTH{w_i[BITWIDTH-1]}}, w_i};
    assign x_ext = {{BITWIDTH{x_i[BITWIDTH-1]}}, x_i};

    // Multiply stage: full-precision product with its valid and group tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
            pg_q   <= '0;
        end else begin
            prod_q <= w_ext * x_ext;
            pv_q   <= valid_i;
            pg_q   <= grp_i;
        end
    end

    // Accumulate stage: clear on start acceptance, otherwise add the tagged product.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            for (int g = 0; g < P; g++) acc_q[g] <= '0;
        end else if (pv_q) begin
            acc_q[pg_q] <= acc_q[pg_q] + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_acc_out
        assign acc_o[g*ACC_W +: ACC_W] = acc_q[g];
    end

endmodule

// File: rtl/matvec_mac_engine.sv
// Restartable out = W*x + b engine. NROW rows share NROW/P MAC lanes, one row
// group at a time; columns are fetched from a 1-cycle-latency BRAM by colAddress.
// Optional build macro MATVEC_MAC_SAT_EN selects saturating (vs wrapping) output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; accumulators cleared when start seen
// ST_CALC   | issuing one (group, column) address per cycle, P*NCOL cycles
// ST_DRAIN1 | last BRAM read returning
// ST_DRAIN2 | last operands in lane registers
// ST_DRAIN3 | last product registered, final accumulate this edge
// ST_WRITE  | bias add, shift, narrow; result and done registered next edge
module matvec_mac_engine
    import matvec_pkg::*;
#(
    parameter int NROW          = 16,
    parameter int NCOL          = 4,
    parameter int QN            = 6,
    parameter int QM            = 11,
    parameter int DSP48_PER_ROW = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [NROW*calc_bitwidth(QN,QM)-1:0]  weightRow,
    input  logic [calc_bitwidth(QN,QM)-1:0]       inputVector,
    input  logic [NROW*calc_bitwidth(QN,QM)-1:0]  biasVector,
    output logic [calc_addr_w(NCOL)-1:0]          colAddress,
    output logic                                  busy,
    output logic                                  done,
    output logic [NROW*calc_bitwidth(QN,QM)-1:0]  outputVector
);

    localparam int P        = DSP48_PER_ROW;
    localparam int BITWIDTH = calc_bitwidth(QN, QM);
    localparam int N_MAC    = NROW / P;
    localparam int ACC_W    = calc_acc_w(BITWIDTH, NCOL);
    localparam int ADDR_W   = calc_addr_w(NCOL);
    localparam int GW       = (clog2(P) < 1) ? 1 : clog2(P);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    col_q, col_d;
    logic [GW-1:0]        grp_q, grp_d;

    logic                 issue_v, wr_en, acc_clr;
    logic                 v1_q, v2_q;
    logic [GW-1:0]        g1_q, g2_q;
    logic [BITWIDTH-1:0]  x2_q;

    logic [NROW*ACC_W-1:0]    acc_all;
    logic [NROW*BITWIDTH-1:0] wr_val;
    logic signed [63:0]       sum_c;

    logic                     busy_q, done_q;
    logic [NROW*BITWIDTH-1:0] out_q;

    // State register with the address/group issue counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            grp_q   <= grp_d;
        end
    end

    // Next state: group outer, column inner; leave CALC after the last issue.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        grp_d   = grp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    col_d   = '0;
                    grp_d   = '0;
                end
            end
            ST_CALC: begin
                if (col_q == ADDR_W'(NCOL - 1)) begin
                    col_d = '0;
                    if (grp_q == GW'(P - 1)) state_d = ST_DRAIN1;
                    else                     grp_d   = grp_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_DRAIN1: state_d = ST_DRAIN2;
            ST_DRAIN2: state_d = ST_DRAIN3;
            ST_DRAIN3: state_d = ST_WRITE;
            ST_WRITE:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM-decoded controls.
    always_comb begin
        issue_v = (state_q == ST_CALC);
        wr_en   = (state_q == ST_WRITE);
        acc_clr = (state_q == ST_IDLE) && start;
    end

    // Valid/group tags following the BRAM read and the lane operand stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            g1_q <= '0;
            v2_q <= 1'b0;
            g2_q <= '0;
            x2_q <= '0;
        end else begin
            v1_q <= issue_v;
            g1_q <= grp_q;
            v2_q <= v1_q;
            g2_q <= g1_q;
            x2_q <= inputVector;
        end
    end

    for (genvar i = 0; i < N_MAC; i++) begin : g_lane
        logic [BITWIDTH-1:0] cand [P];
        logic [BITWIDTH-1:0] w_q;

        // Lane i serves rows i*P+g; pick the row of the group now on the bus.
        for (genvar g = 0; g < P; g++) begin : g_cand
            assign cand[g] = weightRow[(i*P+g)*BITWIDTH +: BITWIDTH];
        end

        // Lane weight operand register.
        always_ff @(posedge clk) begin
            if (reset) w_q <= '0;
            else       w_q <= cand[g1_q];
        end

        mac_lane #(
            .BITWIDTH (BITWIDTH),
            .ACC_W    (ACC_W),
            .P        (P),
            .GW       (GW)
        ) u_mac (
            .clk     (clk),
            .reset   (reset),
            .clear_i (acc_clr),
            .valid_i (v2_q),
            .grp_i   (g2_q),
            .w_i     (w_q),
            .x_i     (x2_q),
            .acc_o   (acc_all[i*P*ACC_W +: P*ACC_W])
        );
    end

    // Bias add in accumulator scale, arithmetic shift back to QM, then narrow.
    always_comb begin
        wr_val = '0;
        sum_c  = '0;
        for (int r = 0; r < NROW; r++) begin
            sum_c = {{(64-ACC_W){acc_all[r*ACC_W+ACC_W-1]}}, acc_all[r*ACC_W +: ACC_W]}
                  + ({{(64-BITWIDTH){biasVector[r*BITWIDTH+BITWIDTH-1]}},
                      biasVector[r*BITWIDTH +: BITWIDTH]} << QM);
            wr_val[r*BITWIDTH +: BITWIDTH] = BITWIDTH'(narrow_result(sum_c >>> QM, BITWIDTH));
        end
    end

    // Registered handshake and result; busy lags the state by one cycle so it
    // covers the done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            out_q  <= '0;
        end else begin
            busy_q <= (state_q != ST_IDLE);
            done_q <= wr_en;
            if (wr_en) out_q <= wr_val;
        end
    end

    assign colAddress   = col_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign outputVector = out_q;

endmodule

// File: tb/tb_matvec_mac_engine.sv
// Directed bench for matvec_mac_engine at default parameters (Q6.11, 1.0 = 2048).
module tb_matvec_mac_engine;

    localparam int NROW = 16;
    localparam int NCOL = 4;
    localparam int BW   = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, start, busy, done;
    logic [NROW*BW-1:0]   weightRow, biasVector, outputVector;
    logic [BW-1:0]        inputVector;
    logic [1:0]           colAddress;

    logic [NROW*BW-1:0]   w_mem [NCOL];
    logic [BW-1:0]        x_mem [NCOL];
    longint               exp_out [NROW];
    int                   total = 0;
    int                   bad = 0;

    matvec_mac_engine dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .weightRow    (weightRow),
        .inputVector  (inputVector),
        .biasVector   (biasVector),
        .colAddress   (colAddress),
        .busy         (busy),
        .done         (done),
        .outputVector (outputVector)
    );

    // BRAM model, one cycle read latency.
    always @(posedge clk) begin
        weightRow   <= w_mem[colAddress];
        inputVector <= x_mem[colAddress];
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint row_out(input int r);
        logic signed [BW-1:0] v;
        v = outputVector[r*BW +: BW];
        return longint'(v);
    endfunction

    task automatic set_w(input int r, input int c, input longint val);
        w_mem[c][r*BW +: BW] = BW'(val);
    endtask

    task automatic fill(input longint w, input longint x, input longint b);
        for (int c = 0; c < NCOL; c++) begin
            x_mem[c] = BW'(x);
            for (int r = 0; r < NROW; r++) set_w(r, c, w);
        end
        for (int r = 0; r < NROW; r++) biasVector[r*BW +: BW] = BW'(b);
    endtask

    task automatic set_exp_all(input longint v);
        for (int r = 0; r < NROW; r++) exp_out[r] = v;
    endtask

    // Caller sits on a negedge; start is sampled on the next posedge (edge 0).
    task automatic run_prod(input string tag, input bit glitch);
        int  n;
        bit  seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            start = glitch && (n == 4 || n == 9);
            if (n == 1) chk({tag, " busy@1"}, longint'(busy), 1);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk({tag, " done cycle"}, seen ? longint'(n) : -1, 20);
        chk({tag, " busy@done"}, longint'(busy), 1);
        for (int r = 0; r < NROW; r++)
            chk($sformatf("%s row%0d", tag, r), row_out(r), exp_out[r]);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        start = 1'b0;
        biasVector = '0;
        fill(0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst busy", longint'(busy), 0);
        chk("rst done", longint'(done), 0);
        chk("rst out nonzero", longint'(outputVector != '0), 0);
        chk("rst colAddress", longint'(colAddress), 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: 0.5 * 1.0 over 4 columns = 2.0
        fill(1024, 2048, 0);
        set_exp_all(4096);
        run_prod("t1", 1'b0);
        @(negedge clk);
        chk("t1 done after", longint'(done), 0);
        chk("t1 busy after", longint'(busy), 0);
        chk("t1 held row0", row_out(0), 4096);

        // 2: bias 0.5, odd rows negated weights
        fill(1024, 2048, 1024);
        for (int r = 1; r < NROW; r += 2)
            for (int c = 0; c < NCOL; c++) set_w(r, c, -1024);
        for (int r = 0; r < NROW; r++) exp_out[r] = (r % 2) ? -3072 : 5120;
        run_prod("t2", 1'b0);
        @(negedge clk);

        // 3: 40.0 * 40.0 * 4 = 6400.0, out of range
        fill(81920, 81920, 0);
`ifdef MATVEC_MAC_SAT_EN
        set_exp_all(131071);
`else
        set_exp_all(0);
`endif
        run_prod("t3pos", 1'b0);
        @(negedge clk);
        fill(-81920, 81920, 0);
`ifdef MATVEC_MAC_SAT_EN
        set_exp_all(-131072);
`else
        set_exp_all(0);
`endif
        run_prod("t3neg", 1'b0);
        @(negedge clk);

        // 4: start pulses at cycles 5 and 10 are ignored
        fill(1024, 2048, 0);
        set_exp_all(4096);
        run_prod("t4", 1'b1);
        count_done(25, cnt);
        chk("t4 extra done", longint'(cnt), 0);

        // 5: reset at cycle 8 aborts the run
        fill(1024, 1024, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5 busy", longint'(busy), 0);
        chk("t5 done", longint'(done), 0);
        chk("t5 out nonzero", longint'(outputVector != '0), 0);
        chk("t5 colAddress", longint'(colAddress), 0);
        count_done(30, cnt);
        chk("t5 no done", longint'(cnt), 0);
        fill(1024, 2048, 0);
        set_exp_all(4096);
        run_prod("t5 rerun", 1'b0);
        @(negedge clk);

        // 6: back-to-back, second start in the cycle after done
        fill(1024, 2048, 0);
        set_exp_all(4096);
        run_prod("t6a", 1'b0);
        fill(1024, 1024, 0);
        set_exp_all(2048);
        run_prod("t6b", 1'b0);
        @(negedge clk);

        // 7: per-column x and per-row weights/bias: out = (r-8)*1280 + 16*r
        for (int c = 0; c < NCOL; c++) begin
            x_mem[c] = BW'((c + 1) * 2048);
            for (int r = 0; r < NROW; r++) set_w(r, c, (r - 8) * 128);
        end
        for (int r = 0; r < NROW; r++) begin
            biasVector[r*BW +: BW] = BW'(r * 16);
            exp_out[r] = (r - 8) * 1280 + r * 16;
        end
        run_prod("t7", 1'b0);
        @(negedge clk);

        // 8: tiny sums truncate toward -inf: +4 -> 0, -4 -> -1
        fill(1, 1, 0);
        for (int r = 1; r < NROW; r += 2)
            for (int c = 0; c < NCOL; c++) set_w(r, c, -1);
        for (int r = 0; r < NROW; r++) exp_out[r] = (r % 2) ? -1 : 0;
        run_prod("t8", 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
